prbs31_test_ctrl: RTL and testbench



---
 rtl/prbs31_pkg.sv | 30 +++
 rtl/prbs31_lfsr.sv | 44 ++++
 rtl/prbs31_test_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_prbs31_test_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs31_pkg.sv
// prbs31_pkg -- shared definitions for the PRBS31 bit-error-rate test block.
//   state_t     : FSM state encoding (also driven out on the 3-bit state port)
//   PRBS_*/TAP_*: polynomial x^31 + x^28 + 1 as register length, tap indices, seed
//   WIN_LEN     : length of the loss-of-lock observation window in rx bits
//   prbs_fb()   : feedback / prediction bit of a 31-bit PRBS register
package prbs31_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    SYNC   = 3'd2,
    LOCKED = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int          PRBS_LEN  = 31;
  localparam int          TAP_A     = 27;
  localparam int          TAP_B     = 30;
  localparam logic [30:0] PRBS_SEED = 31'h1;
  localparam int          WIN_LEN   = 32;

  // LFSR mode select
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  function automatic logic prbs_fb(input logic [30:0] r);
    return r[TAP_A] ^ r[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_lfsr.sv
// prbs31_lfsr -- 31-bit PRBS31 shift register shared by generator and checker.
//   clk, rst_n : clock, asynchronous active-high reset (loads RST_VAL)
//   load       : synchronous load of load_val (wins over en)
//   load_val   : value loaded on load
//   en         : shift one position
//   mode       : MODE_GEN feeds back the taps, MODE_CHK shifts in din
//   din        : serial input used in checker mode
//   msb        : register bit 30 (the generator output bit)
//   pred       : tap XOR, i.e. the predicted next sequence bit
module prbs31_lfsr
  import prbs31_pkg::*;
#(
  parameter logic [30:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [30:0] load_val,
  input  logic        en,
  input  logic        mode,
  input  logic        din,
  output logic        msb,
  output logic        pred
);

  logic [30:0] sr_reg;
  logic        shift_in;

  assign shift_in = (mode == MODE_CHK) ? din : prbs_fb(sr_reg);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sr_reg <= RST_VAL;
    end else if (load) begin
      sr_reg <= load_val;
    end else if (en) begin
      sr_reg <= {sr_reg[PRBS_LEN-2:0], shift_in};
    end
  end

  assign msb  = sr_reg[TAP_B];
  assign pred = prbs_fb(sr_reg);

endmodule

// File: rtl/prbs31_test_ctrl.sv
// prbs31_test_ctrl -- PRBS31 BER test sequencer.
// Seeds and runs a PRBS31 generator onto tx_bit, runs a self-synchronising
// checker on rx_bit, declares lock / loss-of-lock and counts bits and errors
// over a programmable burst.
//   clk, rst_n          : clock, asynchronous active-high reset
//   start/abort/inject  : single-cycle control pulses (abort > start)
//   burst_len           : locked bits per run, 0 = run until abort
//   rx_bit, rx_valid    : received serial stream
//   tx_bit, tx_valid    : generated serial stream (registered)
//   state               : current FSM state (prbs31_pkg::state_t)
//   locked, lock_lost   : in LOCKED / lock dropped during this run (sticky)
//   done                : burst complete
//   err_cnt, err_sat    : saturating error count / saturation seen (sticky)
//   bit_cnt             : locked bits counted this run
module prbs31_test_ctrl
  import prbs31_pkg::*;
#(
  parameter int BURST_W     = 16,
  parameter int ERR_W       = 16,
  parameter int LOCK_THRESH = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               inject,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               rx_bit,
  input  logic               rx_valid,
  output logic               tx_bit,
  output logic               tx_valid,
  output logic [2:0]         state,
  output logic               locked,
  output logic               lock_lost,
  output logic               done,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               err_sat,
  output logic [BURST_W-1:0] bit_cnt
);

  localparam logic [7:0] LOCK_T = LOCK_THRESH[7:0];
  localparam logic [5:0] LOSS_T = LOSS_THRESH[5:0];

  state_t             state_reg;
  logic [7:0]         sync_cnt_reg;
  logic [4:0]         win_bits_reg;
  logic [5:0]         win_errs_reg;
  logic [ERR_W-1:0]   err_cnt_reg;
  logic               err_sat_reg;
  logic [BURST_W-1:0] bit_cnt_reg;
  logic [BURST_W-1:0] burst_reg;
  logic               lock_lost_reg;
  logic               locked_reg;
  logic               done_reg;
  logic               tx_bit_reg;
  logic               tx_valid_reg;
  logic               inj_pend_reg;

  logic               active;
  logic               seed_load;
  logic               gen_msb;
  logic               gen_pred;
  logic               chk_msb;
  logic               chk_pred;
  logic               chk_err;
  logic [7:0]         sync_next;
  logic [5:0]         win_errs_next;
  logic [BURST_W-1:0] bit_cnt_next;
  logic               unused_lfsr_bits;

  assign active        = (state_reg == SYNC) || (state_reg == LOCKED);
  assign seed_load     = (state_reg == SEED);
  assign chk_err       = rx_bit ^ chk_pred;
  assign sync_next     = sync_cnt_reg + 8'd1;
  assign win_errs_next = win_errs_reg + {5'd0, chk_err};
  assign bit_cnt_next  = bit_cnt_reg + BURST_W'(1);

  // Generator: free-running while the test is active.
  prbs31_lfsr #(.RST_VAL(PRBS_SEED)) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (PRBS_SEED),
    .en       (active),
    .mode     (MODE_GEN),
    .din      (1'b0),
    .msb      (gen_msb),
    .pred     (gen_pred)
  );

  // Checker: self-synchronising, shifts only on qualified rx bits.
  prbs31_lfsr #(.RST_VAL(31'h0)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (31'h0),
    .en       (active & rx_valid),
    .mode     (MODE_CHK),
    .din      (rx_bit),
    .msb      (chk_msb),
    .pred     (chk_pred)
  );

  assign unused_lfsr_bits = gen_pred ^ chk_msb;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg     <= IDLE;
      sync_cnt_reg  <= '0;
      win_bits_reg  <= '0;
      win_errs_reg  <= '0;
      err_cnt_reg   <= '0;
      err_sat_reg   <= 1'b0;
      bit_cnt_reg   <= '0;
      burst_reg     <= '0;
      lock_lost_reg <= 1'b0;
      locked_reg    <= 1'b0;
      done_reg      <= 1'b0;
      tx_bit_reg    <= 1'b0;
      tx_valid_reg  <= 1'b0;
      inj_pend_reg  <= 1'b0;
    end else begin
      // Transmit path follows the current state, so it trails a state
      // change by one cycle. A pending inject is consumed by the very next
      // transmitted bit; a new inject pulse re-arms it.
      tx_valid_reg <= active;
      tx_bit_reg   <= active ? (gen_msb ^ inj_pend_reg) : 1'b0;
      inj_pend_reg <= active & inject;

      if (abort) begin
        // Counters and sticky flags stay readable after an abort.
        state_reg  <= IDLE;
        locked_reg <= 1'b0;
        done_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) state_reg <= SEED;
          end

          SEED: begin
            sync_cnt_reg  <= '0;
            win_bits_reg  <= '0;
            win_errs_reg  <= '0;
            err_cnt_reg   <= '0;
            err_sat_reg   <= 1'b0;
            bit_cnt_reg   <= '0;
            lock_lost_reg <= 1'b0;
            burst_reg     <= burst_len;
            state_reg     <= SYNC;
          end

          SYNC: begin
            if (rx_valid) begin
              if (chk_err) begin
                sync_cnt_reg <= '0;
              end else if (sync_next == LOCK_T) begin
                sync_cnt_reg <= '0;
                win_bits_reg <= '0;
                win_errs_reg <= '0;
                locked_reg   <= 1'b1;
                state_reg    <= LOCKED;
              end else begin
                sync_cnt_reg <= sync_next;
              end
            end
          end

          LOCKED: begin
            if (rx_valid) begin
              bit_cnt_reg <= bit_cnt_next;
              if (chk_err) begin
                if (&err_cnt_reg) err_sat_reg <= 1'b1;
                else              err_cnt_reg <= err_cnt_reg + ERR_W'(1);
              end
              // 5-bit bit counter wraps every WIN_LEN valid bits; the error
              // tally restarts with it unless this bit already drops lock.
              win_bits_reg <= win_bits_reg + 5'd1;
              if (win_bits_reg == 5'(WIN_LEN - 1)) win_errs_reg <= '0;
              else                                 win_errs_reg <= win_errs_next;

              // A completed burst wins over a simultaneous loss of lock.
              if ((burst_reg != '0) && (bit_cnt_next == burst_reg)) begin
                locked_reg <= 1'b0;
                done_reg   <= 1'b1;
                state_reg  <= DONE;
              end else if (win_errs_next >= LOSS_T) begin
                locked_reg    <= 1'b0;
                lock_lost_reg <= 1'b1;
                sync_cnt_reg  <= '0;
                state_reg     <= SYNC;
              end
            end
          end

          DONE: begin
            if (start) begin
              done_reg  <= 1'b0;
              state_reg <= SEED;
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign state     = state_reg;
  assign locked    = locked_reg;
  assign lock_lost = lock_lost_reg;
  assign done      = done_reg;
  assign err_cnt   = err_cnt_reg;
  assign err_sat   = err_sat_reg;
  assign bit_cnt   = bit_cnt_reg;
  assign tx_bit    = tx_bit_reg;
  assign tx_valid  = tx_valid_reg;

endmodule

// File: tb/tb_prbs31_test_ctrl.sv
module tb_prbs31_test_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        inject;
  logic [15:0] burst_len;
  logic        force_one;

  // instance a: default widths; instance b: ERR_W=4, same stimulus
  logic        rx_a, rxv_a, tx_a, txv_a, locked_a, lost_a, done_a, sat_a;
  logic [2:0]  state_a;
  logic [15:0] err_a, bits_a;
  logic        rx_b, rxv_b, tx_b, txv_b, locked_b, lost_b, done_b, sat_b;
  logic [2:0]  state_b;
  logic [3:0]  err_b;
  logic [15:0] bits_b;

  int n_checks = 0;
  int n_fail   = 0;
  int lbits    = 0;   // locked bits the bench expects the DUT to have counted
  int cnt_pend = 0;   // a locked bit is visible and will be counted at next edge
  logic exp_q[$];     // expected tx bit stream
  logic prbs[0:63];

  assign rx_a  = force_one ? 1'b1 : tx_a;
  assign rxv_a = txv_a;
  assign rx_b  = force_one ? 1'b1 : tx_b;
  assign rxv_b = txv_b;

  prbs31_test_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inject(inject),
    .burst_len(burst_len), .rx_bit(rx_a), .rx_valid(rxv_a),
    .tx_bit(tx_a), .tx_valid(txv_a), .state(state_a), .locked(locked_a),
    .lock_lost(lost_a), .done(done_a), .err_cnt(err_a), .err_sat(sat_a),
    .bit_cnt(bits_a)
  );

  prbs31_test_ctrl #(.ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inject(inject),
    .burst_len(burst_len), .rx_bit(rx_b), .rx_valid(rxv_b),
    .tx_bit(tx_b), .tx_valid(txv_b), .state(state_b), .locked(locked_b),
    .lock_lost(lost_b), .done(done_b), .err_cnt(err_b), .err_sat(sat_b),
    .bit_cnt(bits_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Advance to the next negedge; account for the locked bit seen last cycle.
  task automatic step();
    if (cnt_pend != 0 && !abort) lbits++;
    @(negedge clk);
    cnt_pend = (locked_a && txv_a) ? 1 : 0;
  endtask

  task automatic wait_lock(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (locked_a) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  // Scoreboard: pop one expected tx bit per valid transmitted bit.
  always @(negedge clk) begin
    if (txv_a && exp_q.size() > 0) check("tx_bit", tx_a, exp_q.pop_front());
  end

  initial begin
    int rxn;
    int ok;
    int exp_e;

    // reference PRBS31 sequence from seed 1: s[n] = s[n-31] ^ s[n-28]
    for (int i = 0; i < 31; i++) prbs[i] = (i == 30);
    for (int i = 31; i < 64; i++) prbs[i] = prbs[i-31] ^ prbs[i-28];

    rst_n = 1'b1; start = 0; abort = 0; inject = 0; burst_len = 16'd0; force_one = 0;
    step(); step();
    check("rst_state", state_a, 0);
    check("rst_txv", txv_a, 0);
    check("rst_err", err_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_done", done_a, 0);
    rst_n = 1'b0;
    step();

    // ---- run 1: loopback, burst of 1000 locked bits ----
    start = 1; burst_len = 16'd1000; lbits = 0;
    for (int i = 0; i < 41; i++) exp_q.push_back(prbs[i]);
    step();
    start = 0;
    check("seed_state", state_a, 1);
    step();
    check("sync_state", state_a, 2);
    check("sync_txv0", txv_a, 0);
    rxn = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (locked_a) begin
        ok = 1;
        break;
      end
      if (txv_a) rxn++;
    end
    check("lock_wait", ok, 1);
    check("lock_rxbits", rxn, 95);
    check("lock_state", state_a, 3);
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (done_a) begin
        ok = 1;
        break;
      end
    end
    check("done_wait", ok, 1);
    check("done_state", state_a, 4);
    check("done_bits", bits_a, 1000);
    check("done_err", err_a, 0);
    check("done_locked", locked_a, 0);
    check("done_lost", lost_a, 0);
    step();
    check("done_txv", txv_a, 0);
    check("done_hold", done_a, 1);

    // ---- run 2: continuous, single inject ----
    burst_len = 16'd0; start = 1; lbits = 0;
    step();
    start = 0;
    wait_lock("lock2_wait");
    repeat (10) step();
    inject = 1;
    step();
    inject = 0;
    repeat (100) step();
    check("inj_err", err_a, 3);
    check("inj_err_b", err_b, 3);
    check("inj_locked", locked_a, 1);
    check("inj_lost", lost_a, 0);

    // ---- abort and start together while locked ----
    abort = 1; start = 1;
    step();
    abort = 0;
    check("abort_state", state_a, 0);
    check("abort_err", err_a, 3);
    check("abort_bits", bits_a, lbits);
    check("abort_done", done_a, 0);
    check("abort_lost", lost_a, 0);
    step();
    start = 0; lbits = 0;
    check("restart_state", state_a, 1);
    step();
    check("restart_sync", state_a, 2);
    check("restart_err", err_a, 0);
    check("restart_bits", bits_a, 0);

    // ---- ERR_W=4 saturation: one inject every 100 bits ----
    wait_lock("lock3_wait");
    for (int i = 1; i <= 6; i++) begin
      inject = 1;
      step();
      inject = 0;
      repeat (99) step();
      exp_e = (3 * i > 15) ? 15 : 3 * i;
      check("sat_err_b", err_b, exp_e);
      check("sat_flag_b", sat_b, (i == 6) ? 1 : 0);
      check("sat_err_a", err_a, 3 * i);
      check("sat_flag_a", sat_a, 0);
      check("sat_locked", locked_a, 1);
    end

    // ---- force rx to 1 from the start of a loss window ----
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (cnt_pend != 0 && (lbits % 32) == 0) begin
        ok = 1;
        break;
      end
    end
    check("win_align", ok, 1);
    force_one = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state_a != 3'd3) begin
        ok = 1;
        break;
      end
    end
    check("loss_wait", ok, 1);
    check("loss_state", state_a, 2);
    check("loss_err", err_a, 18 + 8);
    check("loss_lost", lost_a, 1);
    check("loss_locked", locked_a, 0);
    check("loss_state_b", state_b, 2);
    repeat (300) step();
    check("norelock", locked_a, 0);
    check("norelock_st", state_a, 2);
    check("norelock_err", err_a, 26);

    // ---- asynchronous reset mid-run ----
    #2 rst_n = 1'b1;
    #1;
    check("arst_state", state_a, 0);
    check("arst_txv", txv_a, 0);
    check("arst_err", err_a, 0);
    check("arst_lost", lost_a, 0);
    check("arst_sat_b", sat_b, 0);
    check("arst_bits", bits_a, 0);
    force_one = 0;
    step();
    rst_n = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
